lcd_rx_responder: RTL and testbench

- Synthesizable HD44780-style responder: the receiving end of the 8-bit parallel LCD write bus that the stopwatch LCD transmitter drives (lcd_db/lcd_rs/lcd_e/lcd_p).
- Decodes instructions and data writes into a 2x16 DDRAM shadow and models controller busy time.
- Exposes a read port for on-chip self-check and loopback verification of the stopwatch display text.

---
 rtl/lcd_rx_pkg.sv | 51 +++++
 rtl/lcd_ddram_map.sv | 20 ++
 rtl/lcd_rx_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_rx_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the HD44780-style LCD write-bus responder.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        BUSY
    } state_t;

    // Command classes: an instruction belongs to the class of its highest set bit.
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [7:0] SPACE_CHAR  = 8'h20;
    localparam int         DDRAM_DEPTH = 32;
    localparam int         IDX_W       = 5;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISP,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM,
        OP_DATA
    } op_t;

    function automatic op_t decode_op(input logic rs, input logic [7:0] db);
        if (rs)                           return OP_DATA;
        if ((db & CMD_DDRAM) != 8'h00)    return OP_DDRAM;
        if ((db & CMD_CGRAM) != 8'h00)    return OP_CGRAM;
        if ((db & CMD_FUNC)  != 8'h00)    return OP_FUNC;
        if ((db & CMD_SHIFT) != 8'h00)    return OP_SHIFT;
        if ((db & CMD_DISP)  != 8'h00)    return OP_DISP;
        if ((db & CMD_ENTRY) != 8'h00)    return OP_ENTRY;
        if ((db & CMD_HOME)  != 8'h00)    return OP_HOME;
        if ((db & CMD_CLEAR) != 8'h00)    return OP_CLEAR;
        return OP_NOP;
    endfunction

endpackage

// File: rtl/lcd_ddram_map.sv
// Maps a 7-bit HD44780 DDRAM address onto the 2x16 shadow index (line 2 at 16..31).
module lcd_ddram_map
    import lcd_rx_pkg::*;
(
    input  logic [6:0]       addr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic line1;
    logic line2;

    always_comb begin
        line1 = ((addr & 7'h70) == 7'h00);
        line2 = ((addr & 7'h70) == LINE2_BASE);
        valid = line1 | line2;
        idx   = {line2, addr[3:0]};
    end

endmodule

// File: rtl/lcd_rx_responder.sv
// HD44780-style receiver for the 8-bit LCD write bus: DDRAM shadow, busy timing, read port.
// Optional LCD_RX_4BIT_EN: honour 4-bit (two-nibble) transfers after a function set with dl=0.
module lcd_rx_responder
    import lcd_rx_pkg::*;
#(
    parameter int BUSY_CMD = 2000,
    parameter int BUSY_CLR = 82000,
    parameter int CNT_W    = 17
) (
    input  logic             ckht,
    input  logic             rst,
    input  logic [7:0]       lcd_db,
    input  logic             lcd_rs,
    input  logic             lcd_e,
    input  logic             lcd_p,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_char,
    output logic [IDX_W-1:0] cursor,
    output logic             busy,
    output logic             disp_on,
    output logic             wr_pulse,
    output logic             overrun,
    output logic             addr_err
);

    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(BUSY_CMD);
    localparam logic [CNT_W-1:0] CNT_CLR  = CNT_W'(BUSY_CLR);
    // The fill itself consumes one busy cycle per shadow cell.
    localparam logic [CNT_W-1:0] CNT_TAIL = CNT_W'(BUSY_CLR - DDRAM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DDRAM_DEPTH - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] clr_idx, clr_idx_next;

    logic             e_d;
    logic             id;
    logic             edge_ok;
    logic             take;
    logic             xfer_go;
    logic             xfer_rs;
    logic [7:0]       xfer_db;
    op_t              op;

    logic [IDX_W-1:0] map_idx;
    logic             map_valid;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem [DDRAM_DEPTH];

    assign edge_ok = e_d & ~lcd_e & lcd_p;
    assign take    = edge_ok & (state == IDLE);
    assign op      = decode_op(xfer_rs, xfer_db);

`ifdef LCD_RX_4BIT_EN
    logic       dl;
    logic       phase;
    logic       hi_rs;
    logic [3:0] hi_nib;
    logic       dl_escape;

    // A lone high nibble 0x3 is a function set with dl=1 and exits 4-bit mode at once.
    always_comb begin
        xfer_go   = 1'b0;
        xfer_rs   = lcd_rs;
        xfer_db   = lcd_db;
        dl_escape = ~lcd_rs & (lcd_db[7:4] == 4'h3);
        if (take) begin
            if (dl) begin
                xfer_go = 1'b1;
            end else if (phase) begin
                xfer_go = 1'b1;
                xfer_rs = hi_rs;
                xfer_db = {hi_nib, lcd_db[7:4]};
            end else if (dl_escape) begin
                xfer_go = 1'b1;
                xfer_rs = 1'b0;
                xfer_db = {lcd_db[7:4], 4'h0};
            end
        end
    end

    always_ff @(posedge ckht) begin
        if (rst) begin
            dl     <= 1'b1;
            phase  <= 1'b0;
            hi_rs  <= 1'b0;
            hi_nib <= 4'h0;
        end else if (take) begin
            if (xfer_go) begin
                phase <= 1'b0;
                if (op == OP_FUNC) dl <= xfer_db[4];
            end else begin
                phase  <= 1'b1;
                hi_rs  <= lcd_rs;
                hi_nib <= lcd_db[7:4];
            end
        end
    end
`else
    always_comb begin
        xfer_go = take;
        xfer_rs = lcd_rs;
        xfer_db = lcd_db;
    end
`endif

    lcd_ddram_map u_map (
        .addr  (xfer_db[6:0]),
        .idx   (map_idx),
        .valid (map_valid)
    );

    // FSM state register.
    always_ff @(posedge ckht) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            clr_idx <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_next;
            cnt     <= cnt_next;
            clr_idx <= clr_idx_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
        state_next   = state;
        cnt_next     = cnt;
        clr_idx_next = clr_idx;
        unique case (state)
            IDLE: begin
                if (xfer_go) begin
                    if (op == OP_CLEAR) begin
                        state_next   = CLEAR;
                        clr_idx_next = '0;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = (op == OP_HOME) ? CNT_CLR : CNT_CMD;
                    end
                end
            end
            CLEAR: begin
                clr_idx_next = clr_idx + IDX_W'(1);
                if (clr_idx == LAST_IDX) begin
                    cnt_next   = CNT_TAIL;
                    state_next = (CNT_TAIL == '0) ? IDLE : BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the single shadow write port.
    always_comb begin
        busy      = (state != IDLE);
        mem_we    = 1'b0;
        mem_waddr = cursor;
        mem_wdata = xfer_db;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx;
            mem_wdata = SPACE_CHAR;
        end else if (xfer_go && (op == OP_DATA)) begin
            mem_we = 1'b1;
        end
    end

    // Controller registers updated by executed transfers.
    always_ff @(posedge ckht) begin
        if (rst) begin
            e_d      <= 1'b0;
            cursor   <= '0;
            id       <= 1'b1;
            disp_on  <= 1'b0;
            wr_pulse <= 1'b0;
            overrun  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            e_d      <= lcd_e;
            wr_pulse <= xfer_go && (op == OP_DATA);
            if (edge_ok && busy) overrun <= 1'b1;
            if (xfer_go) begin
                unique case (op)
                    OP_DATA:  cursor <= id ? cursor + IDX_W'(1) : cursor - IDX_W'(1);
                    OP_CLEAR: begin
                        cursor <= '0;
                        id     <= 1'b1;
                    end
                    OP_HOME:  cursor  <= '0;
                    OP_ENTRY: id      <= xfer_db[1];
                    OP_DISP:  disp_on <= xfer_db[2];
                    OP_SHIFT: begin
                        // db[3]=1 is a display shift, which the shadow does not model.
                        if (!xfer_db[3])
                            cursor <= xfer_db[2] ? cursor + IDX_W'(1) : cursor - IDX_W'(1);
                    end
                    OP_DDRAM: begin
                        if (map_valid) cursor   <= map_idx;
                        else           addr_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the shadow array has no reset; clearing it is the job of the clear command.
    always_ff @(posedge ckht) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read-before-write: a same-cycle write to rd_addr shows up one cycle later.
    always_ff @(posedge ckht) begin
        if (rst) rd_char <= 8'h00;
        else     rd_char <= mem[rd_addr];
    end

endmodule

// File: tb/tb_lcd_rx_responder.sv
// Self-checking bench for lcd_rx_responder: command table, corner sequences, shadow readback scoreboard.
`timescale 1ns/1ps
module tb_lcd_rx_responder;

    localparam int BUSY_CMD = 4;
    localparam int BUSY_CLR = 40;

    logic       ckht = 1'b0;
    logic       rst;
    logic [7:0] lcd_db;
    logic       lcd_rs;
    logic       lcd_e;
    logic       lcd_p;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       busy;
    logic       disp_on;
    logic       wr_pulse;
    logic       overrun;
    logic       addr_err;

    lcd_rx_responder #(
        .BUSY_CMD (BUSY_CMD),
        .BUSY_CLR (BUSY_CLR),
        .CNT_W    (17)
    ) dut (
        .ckht     (ckht),
        .rst      (rst),
        .lcd_db   (lcd_db),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_p    (lcd_p),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char),
        .cursor   (cursor),
        .busy     (busy),
        .disp_on  (disp_on),
        .wr_pulse (wr_pulse),
        .overrun  (overrun),
        .addr_err (addr_err)
    );

    always #5 ckht = ~ckht;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        logic [4:0] cur;
        int         busy_len;
        logic       pulse;
        logic       disp;
    } vec_t;

    localparam int NVEC = 21;
    vec_t       vecs [NVEC];
    logic [7:0] exp_mem [32];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ckht);
        #1;
    endtask

    // One E pulse; returns one step after the edge that sees the falling edge.
    task automatic lcd_xfer(input logic rs, input logic [7:0] db);
        lcd_rs = rs;
        lcd_db = db;
        lcd_e  = 1'b1;
        tick();
        lcd_e  = 1'b0;
        tick();
    endtask

    // Counts remaining busy cycles; bounded so a stuck busy still reaches the summary.
    task automatic busy_cycles(output int n);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic readback();
        logic [7:0] exp;
        for (int i = 0; i <= 32; i++) begin
            if (i > 0) begin
                exp = exp_q.pop_front();
                check($sformatf("rd_char[%0d]", i - 1), {24'h0, rd_char}, {24'h0, exp});
            end
            if (i < 32) begin
                rd_addr = 5'(i);
                exp_q.push_back(exp_mem[i]);
            end
            tick();
        end
    endtask

    initial begin
        int n;
        logic [4:0] prev_cur;

        vecs[0]  = '{1'b0, 8'h01, 5'd0,  BUSY_CLR, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h06, 5'd0,  BUSY_CMD, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h8F, 5'd15, BUSY_CMD, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h31, 5'd16, BUSY_CMD, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'h32, 5'd17, BUSY_CMD, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h04, 5'd17, BUSY_CMD, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h80, 5'd0,  BUSY_CMD, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h41, 5'd31, BUSY_CMD, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 8'hC5, 5'd21, BUSY_CMD, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h14, 5'd22, BUSY_CMD, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h10, 5'd21, BUSY_CMD, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h18, 5'd21, BUSY_CMD, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h0C, 5'd21, BUSY_CMD, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 8'h02, 5'd0,  BUSY_CLR, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h06, 5'd0,  BUSY_CMD, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h38, 5'd0,  BUSY_CMD, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 8'h40, 5'd0,  BUSY_CMD, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 5'd0,  BUSY_CMD, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'hCF, 5'd31, BUSY_CMD, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 8'h5A, 5'd0,  BUSY_CMD, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 8'h08, 5'd0,  BUSY_CMD, 1'b0, 1'b0};
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;

        rst = 1'b1; lcd_db = 8'h00; lcd_rs = 1'b0; lcd_e = 1'b0; lcd_p = 1'b1; rd_addr = 5'd0;
        tick();
        tick();
        check("rst_busy",     {31'h0, busy},     32'h0);
        check("rst_cursor",   {27'h0, cursor},   32'h0);
        check("rst_disp_on",  {31'h0, disp_on},  32'h0);
        check("rst_wr_pulse", {31'h0, wr_pulse}, 32'h0);
        check("rst_overrun",  {31'h0, overrun},  32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        check("rst_rd_char",  {24'h0, rd_char},  32'h0);
        rst = 1'b0;
        tick();

        // Command table
        prev_cur = 5'd0;
        for (int i = 0; i < NVEC; i++) begin
            lcd_xfer(vecs[i].rs, vecs[i].db);
            check($sformatf("v%0d_wr_pulse", i), {31'h0, wr_pulse}, {31'h0, vecs[i].pulse});
            busy_cycles(n);
            check($sformatf("v%0d_busy_len", i), n, vecs[i].busy_len);
            check($sformatf("v%0d_cursor", i), {27'h0, cursor}, {27'h0, vecs[i].cur});
            check($sformatf("v%0d_disp_on", i), {31'h0, disp_on}, {31'h0, vecs[i].disp});
            if (vecs[i].rs) exp_mem[prev_cur] = vecs[i].db;
            prev_cur = vecs[i].cur;
        end
        check("tbl_addr_err", {31'h0, addr_err}, 32'h0);
        check("tbl_overrun",  {31'h0, overrun},  32'h0);

        // Read-during-write returns old data, then a second E edge while busy is dropped.
        rd_addr = 5'd0;
        lcd_xfer(1'b1, 8'h55);
        check("rdw_old", {24'h0, rd_char}, 32'h41);
        lcd_rs = 1'b1; lcd_db = 8'h66; lcd_e = 1'b1;
        tick();
        check("rdw_new", {24'h0, rd_char}, 32'h55);
        lcd_e = 1'b0;
        tick();
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        busy_cycles(n);
        check("ovr_busy_left", n, 2);
        check("ovr_cursor", {27'h0, cursor}, 32'd1);
        exp_mem[0] = 8'h55;

        // Out-of-range DDRAM address
        lcd_xfer(1'b0, 8'h90);
        check("aerr_busy", {31'h0, busy}, 32'h1);
        busy_cycles(n);
        check("aerr_flag",   {31'h0, addr_err}, 32'h1);
        check("aerr_cursor", {27'h0, cursor},   32'd1);

        // Panel power off: bus ignored
        lcd_p = 1'b0;
        lcd_xfer(1'b1, 8'h77);
        check("pwr_busy",     {31'h0, busy},     32'h0);
        check("pwr_wr_pulse", {31'h0, wr_pulse}, 32'h0);
        tick();
        check("pwr_cursor",   {27'h0, cursor},   32'd1);
        lcd_p = 1'b1;

`ifdef LCD_RX_4BIT_EN
        lcd_xfer(1'b0, 8'h28);
        busy_cycles(n);
        check("n4_func_busy", n, BUSY_CMD);
        lcd_xfer(1'b1, 8'h40);
        check("n4_hi_busy",  {31'h0, busy},     32'h0);
        check("n4_hi_pulse", {31'h0, wr_pulse}, 32'h0);
        lcd_xfer(1'b1, 8'h50);
        check("n4_lo_pulse", {31'h0, wr_pulse}, 32'h1);
        busy_cycles(n);
        check("n4_lo_busy",  n, BUSY_CMD);
        check("n4_cursor",   {27'h0, cursor}, 32'd2);
        exp_mem[1] = 8'h45;
        lcd_xfer(1'b0, 8'h30);
        busy_cycles(n);
        check("n4_exit_busy", n, BUSY_CMD);
        lcd_xfer(1'b0, 8'h8A);
        busy_cycles(n);
        check("n4_8bit_cursor", {27'h0, cursor}, 32'd10);
`endif

        readback();

        // Reset in the middle of a clear fill
        lcd_xfer(1'b0, 8'h01);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("mrst_busy",     {31'h0, busy},     32'h0);
        check("mrst_cursor",   {27'h0, cursor},   32'h0);
        check("mrst_overrun",  {31'h0, overrun},  32'h0);
        check("mrst_addr_err", {31'h0, addr_err}, 32'h0);
        check("mrst_rd_char",  {24'h0, rd_char},  32'h0);
        rst = 1'b0;
        tick();
        lcd_xfer(1'b0, 8'h06);
        busy_cycles(n);
        check("mrst_cmd_busy", n, BUSY_CMD);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
